uart_cmd_decoder: RTL
=====================

// Module: uart_cmd_decoder
// PURPOSE
//  Byte-level command parser between the UART RX/TX cores and the user
//  register block. Decodes RX byte frames into single register write or read
//  strobes (addr, reg_wr_data, reg_wr_valid, rw, rd_en). Read results are
//  returned as TX bytes, MSB first.
// PARAMETERS
//  ADDR_W       16         register address width; frame carries 2 address bytes
//  DATA_W       16         register data width; frame carries 2 data bytes
//  TIMEOUT_CYC  1000000    max clk cycles between bytes of one frame
// PORTS
//  clk           in   1       system clock
//  reset_n       in   1       asynchronous, active-low reset
//  rx_data       in   8       received byte
//  rx_valid      in   1       1-cycle strobe; rx_data is valid
//  rx_error      in   1       framing/parity error strobe from the UART RX core
//  tx_data       out  8       byte to transmit
//  tx_valid      out  1       tx_data is valid; held until tx_ready
//  tx_ready      in   1       TX core accepts the byte when tx_valid & tx_ready
//  addr          out  ADDR_W  register address
//  reg_wr_data   out  DATA_W  register write data
//  reg_wr_valid  out  1       1-cycle write strobe; rw=0 in the same cycle
//  rw            out  1       1=read, 0=write; held for the whole transaction
//  rd_en         out  1       read request; held high until reg_rd_valid
//  reg_rd_data   in   DATA_W  read data from the register block
//  reg_rd_valid  in   1       1-cycle strobe; reg_rd_data is valid
//  cmd_error     out  1       1-cycle strobe; frame aborted or byte dropped
// BEHAVIOUR
//  - Reset: all outputs are 0 and the state is IDLE. Reset asserted mid-frame
//    or mid-TX aborts immediately, with no strobe emitted.
//  - Frame: cmd, addr_H, addr_L, then data_H, data_L for writes only.
//    cmd 0x57 ('W') = write; cmd 0x52 ('R') = read.
//  - Any other byte in IDLE is discarded and cmd_error pulses.
//  - FSM: IDLE -> ADDR_H -> ADDR_L -> {DATA_H -> DATA_L -> WRITE | READ};
//    READ -> TX_H -> TX_L -> IDLE.
//  - WRITE: exactly one cycle, reg_wr_valid=1, rw=0, then IDLE. Latency from
//    the data_L rx_valid to reg_wr_valid is 1 cycle.
//  - READ: rw=1, rd_en=1 from the cycle after the addr_L strobe. Capture
//    reg_rd_data when reg_rd_valid=1, then drop rd_en in the next cycle.
//    If reg_rd_valid has not arrived 16 cycles after rd_en rises: drop rd_en,
//    pulse cmd_error, return 0xFFFF.
//  - TX_H/TX_L: tx_data = captured[15:8], then [7:0]. tx_valid is held until
//    tx_ready. Each byte advances on tx_valid & tx_ready. tx_data is stable
//    while tx_valid=1.
//  - addr and reg_wr_data are updated only by the byte shifts and hold
//    between frames. rw is cleared in IDLE.
//  - Inter-byte timeout: counter clears on every rx_valid and runs only in
//    ADDR_H/ADDR_L/DATA_H/DATA_L. On reaching TIMEOUT_CYC-1: go to IDLE,
//    pulse cmd_error, emit no strobe.
//  - rx_error in a parse state: abort to IDLE and pulse cmd_error.
//    rx_error in IDLE: pulse cmd_error only.
//  - rx_valid in WRITE/READ/TX_x/ACK: byte dropped, cmd_error pulses, state
//    unchanged.
//  - rx_valid and rx_error in the same cycle: the error wins and the byte is
//    discarded.
// CONFIGURATION
//  CMD_WR_ACK_EN defined:
//    WRITE -> ACK state; sends 0x4B ('K') with the same tx handshake, then IDLE.
//  CMD_WR_ACK_EN undefined:
//    WRITE -> IDLE; no TX activity for writes.
// TESTING
//  1 write: bytes 57 00 03 12 34 -> 1 cycle after the last strobe:
//    reg_wr_valid=1, rw=0, addr=0x0003, reg_wr_data=0x1234.
//  2 read: 52 00 03; the model returns 0x1234 two cycles after rd_en ->
//    rd_en drops after valid; tx bytes 0x12 then 0x34.
//  3 tx backpressure: tx_ready low for 20 cycles during the read response ->
//    tx_valid=1 and tx_data=0x12 stable for all 20 cycles; no byte lost.
//  4 TIMEOUT_CYC=100; send 57 00 then stall 100 cycles -> cmd_error pulse,
//    back in IDLE; a following 52 00 05 read completes normally.
//  5 bad cmd 0x41, then rx_error mid-frame (57 00 <err>) -> 2 cmd_error
//    pulses; no reg_wr_valid or rd_en asserted.
//  6 reset_n low during TX_L, then high -> all outputs 0, no tx_valid;
//    with CMD_WR_ACK_EN, a write frame yields tx byte 0x4B.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// Byte-frame command parser: turns 'W'/'R' UART frames into register strobes
// and sends read data back MSB first. Define CMD_WR_ACK_EN to acknowledge writes with 'K'.
module uart_cmd_decoder #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              rx_error,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic              reg_wr_valid,
  output logic              rw,
  output logic              rd_en,
  input  logic [DATA_W-1:0] reg_rd_data,
  input  logic              reg_rd_valid,
  output logic              cmd_error
);

  localparam logic [7:0]      CmdWrite = 8'h57;
  localparam logic [7:0]      CmdRead  = 8'h52;
  localparam int unsigned     TmoW     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]      RdLast   = 4'd15;
`ifdef CMD_WR_ACK_EN
  localparam logic [7:0]      AckByte  = 8'h4B;
`endif

  typedef enum logic [3:0] {
    StIdle, StAddrH, StAddrL, StDataH, StDataL, StWrite, StRead, StTxH, StTxL, StAck
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [3:0]        rd_cnt_q, rd_cnt_d;
  logic              is_read_q, is_read_d;
  logic              cmd_error_q, cmd_error_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wr_data_q   <= '0;
      rd_data_q   <= '0;
      tmo_q       <= '0;
      rd_cnt_q    <= '0;
      is_read_q   <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      rd_data_q   <= rd_data_d;
      tmo_q       <= tmo_d;
      rd_cnt_q    <= rd_cnt_d;
      is_read_q   <= is_read_d;
      cmd_error_q <= cmd_error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    rd_data_d   = rd_data_q;
    tmo_d       = '0;
    rd_cnt_d    = '0;
    is_read_d   = is_read_q;
    cmd_error_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_error) begin
          cmd_error_d = 1'b1;
        end else if (rx_valid) begin
          if (rx_data == CmdWrite) begin
            is_read_d = 1'b0;
            state_d   = StAddrH;
          end else if (rx_data == CmdRead) begin
            is_read_d = 1'b1;
            state_d   = StAddrH;
          end else begin
            cmd_error_d = 1'b1;
          end
        end
      end

      StAddrH, StAddrL, StDataH, StDataL: begin
        // An error strobe beats a simultaneous byte, which is discarded.
        if (rx_error) begin
          cmd_error_d = 1'b1;
          state_d     = StIdle;
        end else if (rx_valid) begin
          unique case (state_q)
            StAddrH: begin
              addr_d  = {addr_q[ADDR_W-9:0], rx_data};
              state_d = StAddrL;
            end
            StAddrL: begin
              addr_d  = {addr_q[ADDR_W-9:0], rx_data};
              state_d = is_read_q ? StRead : StDataH;
            end
            StDataH: begin
              wr_data_d = {wr_data_q[DATA_W-9:0], rx_data};
              state_d   = StDataL;
            end
            default: begin
              wr_data_d = {wr_data_q[DATA_W-9:0], rx_data};
              state_d   = StWrite;
            end
          endcase
        end else if (tmo_q == TmoLast) begin
          cmd_error_d = 1'b1;
          state_d     = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end

      StWrite: begin
`ifdef CMD_WR_ACK_EN
        state_d = StAck;
`else
        state_d = StIdle;
`endif
      end

      StRead: begin
        if (reg_rd_valid) begin
          rd_data_d = reg_rd_data;
          state_d   = StTxH;
        end else if (rd_cnt_q == RdLast) begin
          // No answer from the register block: report and return all ones.
          rd_data_d   = '1;
          cmd_error_d = 1'b1;
          state_d     = StTxH;
        end else begin
          rd_cnt_d = rd_cnt_q + 4'd1;
        end
      end

      StTxH: if (tx_ready) state_d = StTxL;
      StTxL: if (tx_ready) state_d = StIdle;

`ifdef CMD_WR_ACK_EN
      StAck: if (tx_ready) state_d = StIdle;
`endif

      default: state_d = StIdle;
    endcase

    // Bytes arriving outside a parse state are dropped without disturbing the transaction.
    if (!(state_q inside {StIdle, StAddrH, StAddrL, StDataH, StDataL}) && (rx_valid || rx_error)) begin
      cmd_error_d = 1'b1;
    end
  end

  always_comb begin
    tx_data = 8'h00;
    unique case (state_q)
      StTxH:   tx_data = rd_data_q[DATA_W-1 -: 8];
      StTxL:   tx_data = rd_data_q[7:0];
`ifdef CMD_WR_ACK_EN
      StAck:   tx_data = AckByte;
`endif
      default: tx_data = 8'h00;
    endcase
  end

`ifdef CMD_WR_ACK_EN
  assign tx_valid = state_q inside {StTxH, StTxL, StAck};
`else
  assign tx_valid = state_q inside {StTxH, StTxL};
`endif

  assign reg_wr_valid = (state_q == StWrite);
  assign rd_en        = (state_q == StRead);
  assign rw           = state_q inside {StRead, StTxH, StTxL};
  assign addr         = addr_q;
  assign reg_wr_data  = wr_data_q;
  assign cmd_error    = cmd_error_q;

endmodule
